// File: rtl/ecc_pmul_ctrl_if.sv
// Job handshake (P, k in; R out) and point-op unit handshake of the dP controller.
// The controller is the slave, the host plus op unit are the master.
interface ecc_pmul_ctrl_if #(
    parameter int unsigned DATA_WIDTH = 256
);
    logic                  in_valid;
    logic [DATA_WIDTH-1:0] Px;
    logic [DATA_WIDTH-1:0] Py;
    logic [DATA_WIDTH-1:0] k;
    logic                  busy;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] Rx;
    logic [DATA_WIDTH-1:0] Ry;
    logic                  R_inf;
    logic                  op_req;
    logic                  op_sel;
    logic [DATA_WIDTH-1:0] op_ax;
    logic [DATA_WIDTH-1:0] op_ay;
    logic [DATA_WIDTH-1:0] op_bx;
    logic [DATA_WIDTH-1:0] op_by;
    logic                  op_done;
    logic [DATA_WIDTH-1:0] op_rx;
    logic [DATA_WIDTH-1:0] op_ry;
    logic                  op_rinf;

    modport slave (
        input  in_valid, Px, Py, k, op_done, op_rx, op_ry, op_rinf,
        output busy, out_valid, Rx, Ry, R_inf,
               op_req, op_sel, op_ax, op_ay, op_bx, op_by
    );

    modport master (
        output in_valid, Px, Py, k, op_done, op_rx, op_ry, op_rinf,
        input  busy, out_valid, Rx, Ry, R_inf,
               op_req, op_sel, op_ax, op_ay, op_bx, op_by
    );
endinterface

// File: rtl/ecc_pmul_ctrl.sv
// MSB-first double-and-add sequencer for R = k*P; field arithmetic lives in an
// external point-op unit, the point at infinity is tracked here and never sent out.
module ecc_pmul_ctrl #(
    parameter int unsigned DATA_WIDTH = 256,
    parameter int unsigned CNT_W      = 9
) (
    input  logic           clk,
    input  logic           rst_n,
    ecc_pmul_ctrl_if.slave bus
);
    typedef enum logic [2:0] {IDLE, SCAN, DBL, ADD, DONE} state_e;

    state_e                state_q, state_d;
    logic [CNT_W-1:0]      idx_q, idx_d;
    logic [DATA_WIDTH-1:0] px_q, py_q, k_q;
    logic [DATA_WIDTH-1:0] qx_q, qy_q, qx_d, qy_d;
    logic                  qinf_q, qinf_d;
    logic [DATA_WIDTH-1:0] bit_mask;
    logic                  k_bit, idx_last, op_fin, op_req_d;

    logic                  busy_q, out_valid_q, rinf_q;
    logic [DATA_WIDTH-1:0] rx_q, ry_q;
    logic                  op_req_q, op_sel_q;
    logic [DATA_WIDTH-1:0] op_ax_q, op_ay_q, op_bx_q, op_by_q;

    assign bit_mask = {{(DATA_WIDTH-1){1'b0}}, 1'b1} << idx_q;
    assign k_bit    = |(k_q & bit_mask);
    assign idx_last = (idx_q == '0);
    assign op_fin   = op_req_q & bus.op_done;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        qx_d    = qx_q;
        qy_d    = qy_q;
        qinf_d  = qinf_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = SCAN;
                    idx_d   = CNT_W'(DATA_WIDTH - 1);
                    qinf_d  = 1'b1;
                end
            end
            SCAN: begin
                if (k_bit) begin
                    qx_d   = px_q;
                    qy_d   = py_q;
                    qinf_d = 1'b0;
                end
                if (idx_last) begin
                    state_d = DONE;
                end else begin
                    idx_d = idx_q - CNT_W'(1);
                    if (k_bit) state_d = DBL;
                end
            end
            DBL: begin
                if (qinf_q || op_fin) begin
                    if (!qinf_q) begin
                        qx_d   = bus.op_rx;
                        qy_d   = bus.op_ry;
                        qinf_d = bus.op_rinf;
                    end
                    if (k_bit) begin
                        state_d = ADD;
                    end else if (idx_last) begin
                        state_d = DONE;
                    end else begin
                        idx_d = idx_q - CNT_W'(1);
                    end
                end
            end
            ADD: begin
                // Adding P to infinity is just a copy of P, so no op is issued.
                if (qinf_q || op_fin) begin
                    if (qinf_q) begin
                        qx_d   = px_q;
                        qy_d   = py_q;
                        qinf_d = 1'b0;
                    end else begin
                        qx_d   = bus.op_rx;
                        qy_d   = bus.op_ry;
                        qinf_d = bus.op_rinf;
                    end
                    if (idx_last) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q - CNT_W'(1);
                        state_d = DBL;
                    end
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // The completing edge never re-requests, leaving a one-cycle gap between ops.
    assign op_req_d = ((state_d == DBL) || (state_d == ADD)) && !qinf_d && !op_fin;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            px_q        <= '0;
            py_q        <= '0;
            k_q         <= '0;
            qx_q        <= '0;
            qy_q        <= '0;
            qinf_q      <= 1'b1;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            rx_q        <= '0;
            ry_q        <= '0;
            rinf_q      <= 1'b0;
            op_req_q    <= 1'b0;
            op_sel_q    <= 1'b0;
            op_ax_q     <= '0;
            op_ay_q     <= '0;
            op_bx_q     <= '0;
            op_by_q     <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            qx_q    <= qx_d;
            qy_q    <= qy_d;
            qinf_q  <= qinf_d;
            if (state_q == IDLE && bus.in_valid) begin
                px_q <= bus.Px;
                py_q <= bus.Py;
                k_q  <= bus.k;
            end
            busy_q      <= (state_d != IDLE);
            out_valid_q <= (state_d == DONE);
            if (state_d == DONE) begin
                rx_q   <= qinf_d ? '0 : qx_d;
                ry_q   <= qinf_d ? '0 : qy_d;
                rinf_q <= qinf_d;
            end
            op_req_q <= op_req_d;
            if (op_req_d && !op_req_q) begin
                op_sel_q <= (state_d == ADD);
                op_ax_q  <= qx_d;
                op_ay_q  <= qy_d;
                op_bx_q  <= (state_d == ADD) ? px_q : '0;
                op_by_q  <= (state_d == ADD) ? py_q : '0;
            end
        end
    end

    assign bus.busy      = busy_q;
    assign bus.out_valid = out_valid_q;
    assign bus.Rx        = rx_q;
    assign bus.Ry        = ry_q;
    assign bus.R_inf     = rinf_q;
    assign bus.op_req    = op_req_q;
    assign bus.op_sel    = op_sel_q;
    assign bus.op_ax     = op_ax_q;
    assign bus.op_ay     = op_ay_q;
    assign bus.op_bx     = op_bx_q;
    assign bus.op_by     = op_by_q;
endmodule

// File: tb/tb_ecc_pmul_ctrl.sv
// Bench for ecc_pmul_ctrl: a P-256 point-op unit with 3-cycle latency answers
// the op handshake; golden multiples of G are derived by a different add chain.
module tb_ecc_pmul_ctrl;
    localparam int unsigned DW = 256;
    localparam int unsigned CW = 9;

    typedef logic [DW-1:0] fe_t;
    typedef struct packed { fe_t x; fe_t y; logic inf; } res_t;

    localparam fe_t PRIME = 256'hFFFFFFFF00000001000000000000000000000000FFFFFFFFFFFFFFFFFFFFFFFF;
    localparam fe_t GX    = 256'h6B17D1F2E12C4247F8BCE6E563A440F277037D812DEB33A0F4A13945D898C296;
    localparam fe_t GY    = 256'h4FE342E2FE1A7F9B8EE7EB4A7C0F9E162BCE33576B315ECECBB6406837BF51F5;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ecc_pmul_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    ecc_pmul_ctrl #(.DATA_WIDTH(DW), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int   vectors     = 0;
    int   miscompares = 0;
    res_t exp_q[$];
    logic op_sel_log[$];
    fe_t  op_ax_log[$];
    bit   inj_inf = 1'b0;
    fe_t  g2x, g2y, g3x, g3y, g5x, g5y;
    logic g2i, g3i, g5i;

    // P-256 field arithmetic on reduced operands.
    function automatic fe_t fmul(input fe_t a, input fe_t b);
        logic [2*DW-1:0] t;
        t = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
        t = t % {{DW{1'b0}}, PRIME};
        return t[DW-1:0];
    endfunction

    function automatic fe_t fadd(input fe_t a, input fe_t b);
        logic [DW:0] t;
        t = {1'b0, a} + {1'b0, b};
        if (t >= {1'b0, PRIME}) t = t - {1'b0, PRIME};
        return t[DW-1:0];
    endfunction

    function automatic fe_t fsub(input fe_t a, input fe_t b);
        logic [DW:0] t;
        t = {1'b0, a} - {1'b0, b};
        if (a < b) t = t + {1'b0, PRIME};
        return t[DW-1:0];
    endfunction

    function automatic fe_t finv(input fe_t a);
        fe_t e, r;
        e = PRIME - fe_t'(2);
        r = fe_t'(1);
        for (int i = DW - 1; i >= 0; i--) begin
            r = fmul(r, r);
            if (e[i]) r = fmul(r, a);
        end
        return r;
    endfunction

    function automatic void pdbl(input fe_t x, input fe_t y,
                                 output fe_t rx, output fe_t ry, output logic ri);
        fe_t l;
        if (y == '0) begin
            rx = '0; ry = '0; ri = 1'b1;
        end else begin
            l  = fmul(fsub(fmul(fe_t'(3), fmul(x, x)), fe_t'(3)), finv(fadd(y, y)));
            rx = fsub(fmul(l, l), fadd(x, x));
            ry = fsub(fmul(l, fsub(x, rx)), y);
            ri = 1'b0;
        end
    endfunction

    function automatic void padd(input fe_t x1, input fe_t y1, input fe_t x2, input fe_t y2,
                                 output fe_t rx, output fe_t ry, output logic ri);
        fe_t l;
        if (x1 == x2) begin
            if (y1 == y2) pdbl(x1, y1, rx, ry, ri);
            else begin rx = '0; ry = '0; ri = 1'b1; end
        end else begin
            l  = fmul(fsub(y2, y1), finv(fsub(x2, x1)));
            rx = fsub(fsub(fmul(l, l), x1), x2);
            ry = fsub(fmul(l, fsub(x1, rx)), y1);
            ri = 1'b0;
        end
    endfunction

    // Point-op unit: op_done 3 cycles after op_req rises; abandons the op if op_req drops.
    initial begin : op_model
        fe_t  cax, cay, cbx, cby, rx, ry;
        logic csel, ri;
        bit   aborted;
        bus.op_done = 1'b0;
        bus.op_rx   = '0;
        bus.op_ry   = '0;
        bus.op_rinf = 1'b0;
        forever begin
            @(negedge clk);
            if (bus.op_req === 1'b1) begin
                csel = bus.op_sel; cax = bus.op_ax; cay = bus.op_ay; cbx = bus.op_bx; cby = bus.op_by;
                op_sel_log.push_back(csel);
                op_ax_log.push_back(cax);
                if (csel == 1'b0) begin
                    vectors++;
                    if (cbx !== '0 || cby !== '0) begin
                        miscompares++;
                        $display("FAIL op_b_zero: op_bx=%h op_by=%h, required 0", cbx, cby);
                    end
                    if (inj_inf) begin
                        rx = '0; ry = '0; ri = 1'b1; inj_inf = 1'b0;
                    end else begin
                        pdbl(cax, cay, rx, ry, ri);
                    end
                end else begin
                    padd(cax, cay, cbx, cby, rx, ry, ri);
                end
                aborted = 1'b0;
                for (int c = 0; c < 2; c++) begin
                    @(negedge clk);
                    if (bus.op_req !== 1'b1) begin aborted = 1'b1; break; end
                    vectors++;
                    if ({bus.op_sel, bus.op_ax, bus.op_ay, bus.op_bx, bus.op_by} !== {csel, cax, cay, cbx, cby}) begin
                        miscompares++;
                        $display("FAIL op_stable: sel=%b ax=%h, required sel=%b ax=%h", bus.op_sel, bus.op_ax, csel, cax);
                    end
                end
                if (!aborted) begin
                    bus.op_done = 1'b1; bus.op_rx = rx; bus.op_ry = ry; bus.op_rinf = ri;
                    @(negedge clk);
                    bus.op_done = 1'b0;
                    vectors++;
                    if (bus.op_req !== 1'b0) begin
                        miscompares++;
                        $display("FAIL op_req_drop: op_req=%b after op_done, required 0", bus.op_req);
                    end
                end
            end
        end
    end

    task automatic start_job(input fe_t kk, input fe_t px, input fe_t py);
        @(negedge clk);
        bus.in_valid = 1'b1; bus.k = kk; bus.Px = px; bus.Py = py;
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_out(output bit ok, output int n);
        ok = 1'b0; n = 0;
        while (n < 4000 && !ok) begin
            @(negedge clk);
            n++;
            if (bus.out_valid === 1'b1) ok = 1'b1;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        vectors++;
        if ({bus.busy, bus.out_valid, bus.op_req, bus.op_sel, bus.R_inf} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset_flags: busy/ov/req/sel/rinf=%b, required 00000",
                     {bus.busy, bus.out_valid, bus.op_req, bus.op_sel, bus.R_inf});
        end
        vectors++;
        if (bus.Rx !== '0 || bus.Ry !== '0) begin
            miscompares++;
            $display("FAIL reset_r: Rx=%h Ry=%h, required 0", bus.Rx, bus.Ry);
        end
        vectors++;
        if ({bus.op_ax, bus.op_ay, bus.op_bx, bus.op_by} !== '0) begin
            miscompares++;
            $display("FAIL reset_operands: op_ax=%h, required all operand buses 0", bus.op_ax);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_k0;
        bit ok; int n; res_t e;
        op_sel_log.delete(); op_ax_log.delete();
        exp_q.push_back('{x: '0, y: '0, inf: 1'b1});
        start_job(fe_t'(0), GX, GY);
        wait_out(ok, n);
        e = exp_q.pop_front();
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL k0_timeout: no out_valid after %0d cycles, required one", n); end
        vectors++;
        if ({bus.Rx, bus.Ry, bus.R_inf} !== {e.x, e.y, e.inf}) begin
            miscompares++;
            $display("FAIL k0_result: Rx=%h Ry=%h inf=%b, required %h %h %b", bus.Rx, bus.Ry, bus.R_inf, e.x, e.y, e.inf);
        end
        vectors++;
        if (op_sel_log.size() != 0) begin miscompares++; $display("FAIL k0_ops: %0d ops issued, required 0", op_sel_log.size()); end
        @(negedge clk);
        vectors++;
        if (bus.busy !== 1'b0 || bus.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL k0_after: busy=%b out_valid=%b, required 0 0", bus.busy, bus.out_valid);
        end
    endtask

    task automatic test_k1;
        bit ok; int n; res_t e;
        op_sel_log.delete(); op_ax_log.delete();
        exp_q.push_back('{x: GX, y: GY, inf: 1'b0});
        start_job(fe_t'(1), GX, GY);
        vectors++;
        if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL k1_busy: busy=%b after accept, required 1", bus.busy); end
        wait_out(ok, n);
        e = exp_q.pop_front();
        vectors++;
        if (!ok || n != int'(DW)) begin
            miscompares++;
            $display("FAIL k1_latency: out_valid after %0d edges (seen=%b), required %0d", n, ok, DW);
        end
        vectors++;
        if ({bus.Rx, bus.Ry, bus.R_inf} !== {e.x, e.y, e.inf}) begin
            miscompares++;
            $display("FAIL k1_result: Rx=%h Ry=%h inf=%b, required %h %h %b", bus.Rx, bus.Ry, bus.R_inf, e.x, e.y, e.inf);
        end
        vectors++;
        if (op_sel_log.size() != 0) begin miscompares++; $display("FAIL k1_ops: %0d ops issued, required 0", op_sel_log.size()); end
    endtask

    task automatic test_double_add;
        fe_t      kk   [3];
        res_t     ex   [3];
        int       nops [3];
        logic [2:0] sels [3];
        bit ok; int n; res_t e;
        kk[0] = fe_t'(2); ex[0] = '{x: g2x, y: g2y, inf: g2i}; nops[0] = 1; sels[0] = 3'b000;
        kk[1] = fe_t'(3); ex[1] = '{x: g3x, y: g3y, inf: g3i}; nops[1] = 2; sels[1] = 3'b010;
        kk[2] = fe_t'(5); ex[2] = '{x: g5x, y: g5y, inf: g5i}; nops[2] = 3; sels[2] = 3'b100;
        for (int t = 0; t < 3; t++) begin
            op_sel_log.delete(); op_ax_log.delete();
            exp_q.push_back(ex[t]);
            start_job(kk[t], GX, GY);
            wait_out(ok, n);
            e = exp_q.pop_front();
            vectors++;
            if (!ok) begin miscompares++; $display("FAIL k%0d_timeout: no out_valid after %0d cycles", kk[t], n); end
            vectors++;
            if ({bus.Rx, bus.Ry, bus.R_inf} !== {e.x, e.y, e.inf}) begin
                miscompares++;
                $display("FAIL k%0d_result: Rx=%h Ry=%h inf=%b, required %h %h %b", kk[t], bus.Rx, bus.Ry, bus.R_inf, e.x, e.y, e.inf);
            end
            vectors++;
            if (op_sel_log.size() != nops[t]) begin
                miscompares++;
                $display("FAIL k%0d_ops: %0d ops issued, required %0d", kk[t], op_sel_log.size(), nops[t]);
            end else begin
                for (int j = 0; j < nops[t]; j++) begin
                    vectors++;
                    if (op_sel_log[j] !== sels[t][j]) begin
                        miscompares++;
                        $display("FAIL k%0d_sel%0d: op_sel=%b, required %b", kk[t], j, op_sel_log[j], sels[t][j]);
                    end
                end
                vectors++;
                if (op_ax_log[0] !== GX) begin
                    miscompares++;
                    $display("FAIL k%0d_first_ax: op_ax=%h, required %h", kk[t], op_ax_log[0], GX);
                end
            end
        end
    endtask

    task automatic test_inf_inject;
        bit ok; int n; res_t e;
        op_sel_log.delete(); op_ax_log.delete();
        inj_inf = 1'b1;
        exp_q.push_back('{x: GX, y: GY, inf: 1'b0});
        start_job(fe_t'(3), GX, GY);
        wait_out(ok, n);
        e = exp_q.pop_front();
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL inf_timeout: no out_valid after %0d cycles", n); end
        vectors++;
        if ({bus.Rx, bus.Ry, bus.R_inf} !== {e.x, e.y, e.inf}) begin
            miscompares++;
            $display("FAIL inf_result: Rx=%h Ry=%h inf=%b, required %h %h %b", bus.Rx, bus.Ry, bus.R_inf, e.x, e.y, e.inf);
        end
        vectors++;
        if (op_sel_log.size() != 1) begin miscompares++; $display("FAIL inf_ops: %0d ops issued, required 1", op_sel_log.size()); end
    endtask

    task automatic test_busy_ignore;
        bit ok; int n; res_t e;
        op_sel_log.delete(); op_ax_log.delete();
        exp_q.push_back('{x: g5x, y: g5y, inf: g5i});
        start_job(fe_t'(5), GX, GY);
        repeat (4) @(negedge clk);
        bus.in_valid = 1'b1; bus.k = fe_t'(7); bus.Px = fe_t'(256'h1234); bus.Py = fe_t'(256'h5678);
        @(negedge clk);
        bus.in_valid = 1'b0;
        vectors++;
        if (bus.busy !== 1'b1) begin miscompares++; $display("FAIL ignore_busy: busy=%b during job, required 1", bus.busy); end
        wait_out(ok, n);
        e = exp_q.pop_front();
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL ignore_timeout: no out_valid after %0d cycles", n); end
        vectors++;
        if ({bus.Rx, bus.Ry, bus.R_inf} !== {e.x, e.y, e.inf}) begin
            miscompares++;
            $display("FAIL ignore_result: Rx=%h Ry=%h inf=%b, required %h %h %b", bus.Rx, bus.Ry, bus.R_inf, e.x, e.y, e.inf);
        end
        vectors++;
        if (op_sel_log.size() != 3) begin miscompares++; $display("FAIL ignore_ops: %0d ops issued, required 3", op_sel_log.size()); end
        exp_q.push_back('{x: g3x, y: g3y, inf: g3i});
        start_job(fe_t'(3), GX, GY);
        wait_out(ok, n);
        e = exp_q.pop_front();
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL next_timeout: no out_valid after %0d cycles", n); end
        vectors++;
        if ({bus.Rx, bus.Ry, bus.R_inf} !== {e.x, e.y, e.inf}) begin
            miscompares++;
            $display("FAIL next_result: Rx=%h Ry=%h inf=%b, required %h %h %b", bus.Rx, bus.Ry, bus.R_inf, e.x, e.y, e.inf);
        end
    endtask

    task automatic test_reset_mid;
        bit ok; int n; int pulses;
        start_job(fe_t'(2), GX, GY);
        ok = 1'b0; n = 0;
        while (n < 4000 && !ok) begin
            @(negedge clk);
            n++;
            if (bus.op_req === 1'b1) ok = 1'b1;
        end
        vectors++;
        if (!ok) begin miscompares++; $display("FAIL rst_wait_req: op_req not seen after %0d cycles, required 1", n); end
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({bus.op_req, bus.busy, bus.out_valid} !== 3'b000) begin
            miscompares++;
            $display("FAIL rst_abort: req/busy/ov=%b, required 000", {bus.op_req, bus.busy, bus.out_valid});
        end
        pulses = 0;
        repeat (3) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) pulses++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (bus.out_valid !== 1'b0) pulses++;
        end
        vectors++;
        if (pulses != 0) begin miscompares++; $display("FAIL rst_no_result: %0d out_valid cycles, required 0", pulses); end
        op_sel_log.delete(); op_ax_log.delete();
        exp_q.push_back('{x: g2x, y: g2y, inf: g2i});
        start_job(fe_t'(2), GX, GY);
        wait_out(ok, n);
        begin
            res_t e;
            e = exp_q.pop_front();
            vectors++;
            if (!ok) begin miscompares++; $display("FAIL rst_after_timeout: no out_valid after %0d cycles", n); end
            vectors++;
            if ({bus.Rx, bus.Ry, bus.R_inf} !== {e.x, e.y, e.inf}) begin
                miscompares++;
                $display("FAIL rst_after_result: Rx=%h Ry=%h inf=%b, required %h %h %b", bus.Rx, bus.Ry, bus.R_inf, e.x, e.y, e.inf);
            end
            vectors++;
            if (op_sel_log.size() != 1) begin miscompares++; $display("FAIL rst_after_ops: %0d ops issued, required 1", op_sel_log.size()); end
        end
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin : main
        bus.in_valid = 1'b0;
        bus.Px = '0;
        bus.Py = '0;
        bus.k  = '0;
        // 5G is built as 3G + 2G, a different chain from the controller's 4G + G.
        pdbl(GX, GY, g2x, g2y, g2i);
        padd(g2x, g2y, GX, GY, g3x, g3y, g3i);
        padd(g3x, g3y, g2x, g2y, g5x, g5y, g5i);
        test_reset();
        test_k0();
        test_k1();
        test_double_add();
        test_inf_inject();
        test_busy_ignore();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
